// File: rtl/beat_sequencer.sv
// beat_sequencer: tempo-driven step scheduler for the rhythm game datapath.
// Holds a 4-lane step pattern memory, derives its own beat tick from a
// programmable clocks-per-beat period and emits one step per beat as a
// single-cycle shift enable plus data. Supports lead-in blanking, song
// length, looping, pause and abort.
module beat_sequencer #(
  parameter int unsigned LEAD_IN_BEATS = 4,
  parameter int unsigned ADDR_W        = 6,
  parameter int unsigned TEMPO_W       = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic               pause_i,
  input  logic               loop_i,
  input  logic [TEMPO_W-1:0] tempo_period_i,
  input  logic [ADDR_W-1:0]  song_len_i,
  input  logic               pat_we_i,
  input  logic [ADDR_W-1:0]  pat_waddr_i,
  input  logic [3:0]         pat_wdata_i,
  output logic [3:0]         step_out_o,
  output logic               step_valid_o,
  output logic [ADDR_W-1:0]  beat_idx_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  // Lead counter only needs to reach LEAD_IN_BEATS-1.
  localparam int unsigned LeadW = (LEAD_IN_BEATS > 1) ? $clog2(LEAD_IN_BEATS) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StLeadIn,
    StPlay,
    StDone
  } state_e;

  state_e             state_q, state_d;
  logic [TEMPO_W-1:0] period_q, period_d;
  logic [ADDR_W-1:0]  len_last_q, len_last_d;
  logic [TEMPO_W-1:0] cnt_q, cnt_d;
  logic [LeadW-1:0]   lead_q, lead_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [3:0]         step_out_q, step_out_d;
  logic               step_valid_q, step_valid_d;

  logic [3:0]         mem_q [Depth];

  logic               running;
  logic               tick;
  logic               lead_last;
  logic               song_last;

  assign running   = (state_q == StLeadIn) || (state_q == StPlay);
  // A tick is the wrap of the beat counter; pause holds the counter so the
  // tick is simply deferred until pause drops.
  assign tick      = running && !pause_i && (cnt_q == (period_q - TEMPO_W'(1)));
  assign lead_last = (32'(lead_q) == (LEAD_IN_BEATS - 1));
  // song_len of 0 wraps to all-ones here, which gives the full 2^ADDR_W song.
  assign song_last = (idx_q == len_last_q);

  // Pattern memory: plain synchronous write, never reset. The read below is
  // combinational off the current contents, so a same-cycle write to the
  // address being emitted still emits the old data.
  always_ff @(posedge clk) begin
    if (pat_we_i) begin
      mem_q[pat_waddr_i] <= pat_wdata_i;
    end
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      period_q     <= TEMPO_W'(2);
      len_last_q   <= '0;
      cnt_q        <= '0;
      lead_q       <= '0;
      idx_q        <= '0;
      step_out_q   <= '0;
      step_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      period_q     <= period_d;
      len_last_q   <= len_last_d;
      cnt_q        <= cnt_d;
      lead_q       <= lead_d;
      idx_q        <= idx_d;
      step_out_q   <= step_out_d;
      step_valid_q <= step_valid_d;
    end
  end

  // Next-state: abort beats start beats tick; step_valid defaults low so it
  // is always a single-cycle pulse.
  always_comb begin
    state_d      = state_q;
    period_d     = period_q;
    len_last_d   = len_last_q;
    cnt_d        = cnt_q;
    lead_d       = lead_q;
    idx_d        = idx_q;
    step_out_d   = step_out_q;
    step_valid_d = 1'b0;

    if (abort_i) begin
      state_d = StIdle;
      cnt_d   = '0;
      lead_d  = '0;
      idx_d   = '0;
    end else if (start_i && ((state_q == StIdle) || (state_q == StDone))) begin
      state_d    = (LEAD_IN_BEATS == 0) ? StPlay : StLeadIn;
      // Periods below 2 would give back-to-back pulses; clamp to 2.
      period_d   = (tempo_period_i < TEMPO_W'(2)) ? TEMPO_W'(2) : tempo_period_i;
      len_last_d = song_len_i - ADDR_W'(1);
      cnt_d      = '0;
      lead_d     = '0;
      idx_d      = '0;
    end else if (running && !pause_i) begin
      if (tick) begin
        cnt_d        = '0;
        step_valid_d = 1'b1;
        if (state_q == StLeadIn) begin
          step_out_d = 4'b0000;
          if (lead_last) begin
            state_d = StPlay;
          end else begin
            lead_d = lead_q + LeadW'(1);
          end
        end else begin
          step_out_d = mem_q[idx_q];
          if (song_last) begin
            idx_d = '0;
            if (!loop_i) begin
              state_d = StDone;
            end
          end else begin
            idx_d = idx_q + ADDR_W'(1);
          end
        end
      end else begin
        cnt_d = cnt_q + TEMPO_W'(1);
      end
    end
  end

  // Outputs: step data/valid are registered; status decodes the state.
  always_comb begin
    step_out_o   = step_out_q;
    step_valid_o = step_valid_q;
    beat_idx_o   = idx_q;
    busy_o       = running;
    done_o       = (state_q == StDone);
  end

endmodule

// File: tb/tb_beat_sequencer.sv
// Self-checking bench for beat_sequencer: expected pulses (edge number and
// data) are queued as each song is started and popped by a monitor on every
// step_valid pulse.
module tb_beat_sequencer;

  localparam int unsigned Lead = 4;
  localparam int unsigned Aw   = 2;
  localparam int unsigned Tw   = 24;

  logic          clk = 1'b0;
  logic          reset;
  logic          start_i, abort_i, pause_i, loop_i;
  logic [Tw-1:0] tempo_period_i;
  logic [Aw-1:0] song_len_i;
  logic          pat_we_i;
  logic [Aw-1:0] pat_waddr_i;
  logic [3:0]    pat_wdata_i;
  logic [3:0]    step_out_o;
  logic          step_valid_o;
  logic [Aw-1:0] beat_idx_o;
  logic          busy_o, done_o;

  beat_sequencer #(
    .LEAD_IN_BEATS (Lead),
    .ADDR_W        (Aw),
    .TEMPO_W       (Tw)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start_i        (start_i),
    .abort_i        (abort_i),
    .pause_i        (pause_i),
    .loop_i         (loop_i),
    .tempo_period_i (tempo_period_i),
    .song_len_i     (song_len_i),
    .pat_we_i       (pat_we_i),
    .pat_waddr_i    (pat_waddr_i),
    .pat_wdata_i    (pat_wdata_i),
    .step_out_o     (step_out_o),
    .step_valid_o   (step_valid_o),
    .beat_idx_o     (beat_idx_o),
    .busy_o         (busy_o),
    .done_o         (done_o)
  );

  always #5 clk = ~clk;

  // Edge counter: after rising edge k, cyc == k.
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned at;
    logic [3:0]  data;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_errors = 0;
  logic prev_v   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, want, cyc);
    end
  endtask

  // Monitor: every pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (step_valid_o) begin
      check("back_to_back", 32'(prev_v), 32'd0);
      if (exp_q.size() == 0) begin
        check("spurious_pulse", 32'(step_valid_o), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("step_data", 32'(step_out_o), 32'(e.data));
        check("step_time", cyc, e.at);
      end
    end
    prev_v = step_valid_o;
  end

  task automatic push(input int unsigned at, input logic [3:0] d);
    exp_t x;
    x.at   = at;
    x.data = d;
    exp_q.push_back(x);
  endtask

  task automatic push_lead(input int unsigned t, input int unsigned per);
    for (int k = 1; k <= int'(Lead); k++) push(t + per * k, 4'h0);
  endtask

  // Return at the negedge just before edge e, so a drive now is seen at e.
  task automatic to_edge(input int unsigned e_at);
    while (cyc + 1 < e_at) @(negedge clk);
  endtask

  task automatic do_start(output int unsigned t);
    start_i = 1'b1;
    t = cyc + 1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic write_mem(input logic [Aw-1:0] a, input logic [3:0] d);
    pat_we_i    = 1'b1;
    pat_waddr_i = a;
    pat_wdata_i = d;
    @(negedge clk);
    pat_we_i = 1'b0;
  endtask

  int unsigned t;

  initial begin
    reset = 1'b1;
    start_i = 0; abort_i = 0; pause_i = 0; loop_i = 0;
    tempo_period_i = '0; song_len_i = '0;
    pat_we_i = 0; pat_waddr_i = '0; pat_wdata_i = '0;
    repeat (3) @(negedge clk);
    check("rst_step_out", 32'(step_out_o), 32'd0);
    check("rst_step_valid", 32'(step_valid_o), 32'd0);
    check("rst_beat_idx", 32'(beat_idx_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    reset = 1'b0;
    write_mem(2'd0, 4'h1);
    write_mem(2'd1, 4'h2);
    write_mem(2'd2, 4'h4);
    write_mem(2'd3, 4'h8);

    // Basic song, no loop.
    tempo_period_i = 24'd10; song_len_i = 2'd3; loop_i = 0;
    do_start(t);
    check("busy_after_start", 32'(busy_o), 32'd1);
    push_lead(t, 10);
    push(t + 50, 4'h1); push(t + 60, 4'h2); push(t + 70, 4'h4);
    to_edge(t + 61);
    check("beat_idx_mid", 32'(beat_idx_o), 32'd2);
    to_edge(t + 70);
    check("done_before_last", 32'(done_o), 32'd0);
    to_edge(t + 71);
    check("done_at_last", 32'(done_o), 32'd1);
    check("busy_at_last", 32'(busy_o), 32'd0);
    check("beat_idx_done", 32'(beat_idx_o), 32'd0);
    repeat (30) @(negedge clk);
    check("pending_basic", exp_q.size(), 32'd0);

    // Looping song; mid-song start and tempo/len changes ignored; abort on tick.
    loop_i = 1;
    do_start(t);
    tempo_period_i = 24'd3; song_len_i = 2'd1;
    push_lead(t, 10);
    push(t + 50, 4'h1); push(t + 60, 4'h2); push(t + 70, 4'h4);
    push(t + 80, 4'h1); push(t + 90, 4'h2);
    to_edge(t + 33);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    to_edge(t + 76);
    check("loop_wrap_idx", 32'(beat_idx_o), 32'd0);
    check("loop_busy", 32'(busy_o), 32'd1);
    to_edge(t + 100);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    check("abort_busy", 32'(busy_o), 32'd0);
    check("abort_idx", 32'(beat_idx_o), 32'd0);
    check("abort_done", 32'(done_o), 32'd0);
    repeat (20) @(negedge clk);
    check("pending_loop", exp_q.size(), 32'd0);

    // Restart after abort begins with lead-in.
    tempo_period_i = 24'd10; song_len_i = 2'd3; loop_i = 0;
    do_start(t);
    push_lead(t, 10);
    push(t + 50, 4'h1);
    to_edge(t + 55);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    repeat (20) @(negedge clk);
    check("pending_restart", exp_q.size(), 32'd0);

    // Degenerate periods clamp to 2.
    for (int p = 0; p < 2; p++) begin
      tempo_period_i = Tw'(p); song_len_i = 2'd3; loop_i = 0;
      do_start(t);
      push_lead(t, 2);
      push(t + 10, 4'h1); push(t + 12, 4'h2); push(t + 14, 4'h4);
      to_edge(t + 20);
      check("short_done", 32'(done_o), 32'd1);
      check("pending_short", exp_q.size(), 32'd0);
    end

    // Pause on a would-be tick (3 cycles) and mid-beat (5 cycles).
    tempo_period_i = 24'd10; song_len_i = 2'd3; loop_i = 0;
    do_start(t);
    push(t + 10, 4'h0); push(t + 23, 4'h0); push(t + 33, 4'h0); push(t + 43, 4'h0);
    push(t + 53, 4'h1); push(t + 68, 4'h2); push(t + 78, 4'h4);
    to_edge(t + 20); pause_i = 1'b1;
    to_edge(t + 23); pause_i = 1'b0;
    to_edge(t + 56); pause_i = 1'b1;
    to_edge(t + 61); pause_i = 1'b0;
    to_edge(t + 90);
    check("pause_done", 32'(done_o), 32'd1);
    check("pending_pause", exp_q.size(), 32'd0);

    // Full-depth song (len 0) with a write to the emitting address on a tick.
    tempo_period_i = 24'd4; song_len_i = 2'd0; loop_i = 1;
    do_start(t);
    push_lead(t, 4);
    push(t + 20, 4'h1); push(t + 24, 4'h2); push(t + 28, 4'h4); push(t + 32, 4'h8);
    push(t + 36, 4'h1); push(t + 40, 4'hF); push(t + 44, 4'h4); push(t + 48, 4'h8);
    to_edge(t + 24);
    write_mem(2'd1, 4'hF);
    to_edge(t + 34);
    loop_i = 0;
    to_edge(t + 48);
    check("full_not_done", 32'(done_o), 32'd0);
    to_edge(t + 49);
    check("full_done", 32'(done_o), 32'd1);
    repeat (20) @(negedge clk);
    check("pending_full", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
